// File: rtl/acc_pkg.sv
// -----------------------------------------------------------------------------
// acc_pkg
// Shared types for the accelerator memory (cmem) channel.
//   mem_req_type_e   : load/store selector carried on the cmem request channel
//   cmem_size_e      : access size encoding (3 is illegal and has no name)
//   cmem_rsp_state_e : control states of acc_cmem_responder
// -----------------------------------------------------------------------------
package acc_pkg;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } mem_req_type_e;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } cmem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RSP  = 2'd3
    } cmem_rsp_state_e;

endpackage

// File: rtl/acc_cmem_align.sv
// -----------------------------------------------------------------------------
// acc_cmem_align
// Purely combinational lane steering between the LSB-aligned cmem view and
// the word-aligned OBI view. The store path and the load path have separate
// offset/size inputs so one instance can serve an incoming request (store
// side) and a pending transaction (load side) at the same time.
//
// Ports
//   wr_off_i   [1:0]  byte offset of the store/request
//   wr_size_i  [1:0]  size of the store/request
//   wdata_i    [31:0] LSB-aligned store data
//   be_o       [3:0]  OBI byte enables (0 for illegal size)
//   wdata_o    [31:0] lane-steered store data
//   rd_off_i   [1:0]  byte offset of the load
//   rd_size_i  [1:0]  size of the load
//   rdata_i    [31:0] raw OBI read data
//   rdata_o    [31:0] LSB-aligned, zero-extended load data
// -----------------------------------------------------------------------------
module acc_cmem_align
    import acc_pkg::*;
(
    input  logic [1:0]  wr_off_i,
    input  logic [1:0]  wr_size_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    input  logic [1:0]  rd_off_i,
    input  logic [1:0]  rd_size_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] rdata_o
);

    logic [31:0] rdata_shifted;

    // Store side: bytes are replicated into every lane so the enabled lane
    // always carries the byte regardless of offset.
    always_comb begin
        be_o    = 4'b0000;
        wdata_o = 32'h0;
        case (wr_size_i)
            BYTE: begin
                be_o    = 4'b0001 << wr_off_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            HALF: begin
                be_o    = 4'b0011 << wr_off_i;
                wdata_o = {16'h0, wdata_i[15:0]} << {wr_off_i, 3'b000};
            end
            WORD: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
            end
            default: begin
                be_o    = 4'b0000;
                wdata_o = 32'h0;
            end
        endcase
    end

    // Load side: bring the addressed lane down to bit 0, then mask to size.
    always_comb begin
        rdata_shifted = rdata_i >> {rd_off_i, 3'b000};
        rdata_o       = 32'h0;
        case (rd_size_i)
            BYTE:    rdata_o = {24'h0, rdata_shifted[7:0]};
            HALF:    rdata_o = {16'h0, rdata_shifted[15:0]};
            WORD:    rdata_o = rdata_shifted;
            default: rdata_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/acc_cmem_responder.sv
// -----------------------------------------------------------------------------
// acc_cmem_responder
// Core-side responder for the accelerator memory (cmem) channel. Takes one
// load/store at a time from the cmem request channel, performs it on the OBI
// data port and returns exactly one response. Illegal requests (probe mode,
// size 3, misaligned half/word) are answered with an error and never reach
// the bus.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   cmem_q_*                      request channel (valid/ready, addr, wdata,
//                                 size, req_type, mode, spec, eot, id)
//   cmem_p_*                      response channel (valid/ready, rdata,
//                                 status, id)
//   data_req_o/data_gnt_i         OBI address phase
//   data_addr_o/we_o/be_o/wdata_o OBI address-phase payload (registered)
//   data_rvalid_i/rdata_i/err_i   OBI response phase
//
// Every output is a register or a decode of the state register.
// -----------------------------------------------------------------------------
module acc_cmem_responder
    import acc_pkg::*;
#(
    parameter int unsigned ID_WIDTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,

    input  logic                cmem_q_valid_i,
    output logic                cmem_q_ready_o,
    input  logic [31:0]         cmem_q_addr_i,
    input  logic [31:0]         cmem_q_wdata_i,
    input  logic [1:0]          cmem_q_size_i,
    input  mem_req_type_e       cmem_q_req_type_i,
    input  logic                cmem_q_mode_i,
    input  logic                cmem_q_spec_i,
    input  logic                cmem_q_endoftransaction_i,
    input  logic [ID_WIDTH-1:0] cmem_q_id_i,

    output logic                cmem_p_valid_o,
    input  logic                cmem_p_ready_i,
    output logic [31:0]         cmem_p_rdata_o,
    output logic                cmem_p_status_o,
    output logic [ID_WIDTH-1:0] cmem_p_id_o,

    output logic                data_req_o,
    input  logic                data_gnt_i,
    output logic [31:0]         data_addr_o,
    output logic                data_we_o,
    output logic [3:0]          data_be_o,
    output logic [31:0]         data_wdata_o,
    input  logic                data_rvalid_i,
    input  logic [31:0]         data_rdata_i,
    input  logic                data_err_i
);

    cmem_rsp_state_e     state_q, state_d;

    // Pending transaction context needed to post-process the read data.
    logic [1:0]          off_q, off_d;
    logic [1:0]          size_q, size_d;
    mem_req_type_e       type_q, type_d;
    logic [ID_WIDTH-1:0] id_q, id_d;

    // Registered OBI address-phase payload.
    logic [31:0]         data_addr_q, data_addr_d;
    logic                data_we_q, data_we_d;
    logic [3:0]          data_be_q, data_be_d;
    logic [31:0]         data_wdata_q, data_wdata_d;

    // Registered response payload.
    logic [31:0]         rdata_q, rdata_d;
    logic                status_q, status_d;

    logic [3:0]          al_be;
    logic [31:0]         al_wdata;
    logic [31:0]         al_rdata;
    logic                misaligned;
    logic                req_legal;

    // Speculation and transaction grouping carry no meaning here.
    logic                unused_inputs;
    assign unused_inputs = cmem_q_spec_i ^ cmem_q_endoftransaction_i;

    // Store steering uses the incoming request so the payload can be
    // registered on the accept edge; load extraction uses the latched context.
    acc_cmem_align u_align (
        .wr_off_i  (cmem_q_addr_i[1:0]),
        .wr_size_i (cmem_q_size_i),
        .wdata_i   (cmem_q_wdata_i),
        .be_o      (al_be),
        .wdata_o   (al_wdata),
        .rd_off_i  (off_q),
        .rd_size_i (size_q),
        .rdata_i   (data_rdata_i),
        .rdata_o   (al_rdata)
    );

    always_comb begin
        misaligned = 1'b0;
        case (cmem_q_size_i)
            HALF:    misaligned = cmem_q_addr_i[0];
            WORD:    misaligned = (cmem_q_addr_i[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    assign req_legal = !cmem_q_mode_i && (cmem_q_size_i != 2'd3) && !misaligned;

    always_comb begin
        state_d      = state_q;
        off_d        = off_q;
        size_d       = size_q;
        type_d       = type_q;
        id_d         = id_q;
        data_addr_d  = data_addr_q;
        data_we_d    = data_we_q;
        data_be_d    = data_be_q;
        data_wdata_d = data_wdata_q;
        rdata_d      = rdata_q;
        status_d     = status_q;

        case (state_q)
            IDLE: begin
                if (cmem_q_valid_i) begin
                    off_d  = cmem_q_addr_i[1:0];
                    size_d = cmem_q_size_i;
                    type_d = cmem_q_req_type_i;
                    id_d   = cmem_q_id_i;
                    if (req_legal) begin
                        data_addr_d  = {cmem_q_addr_i[31:2], 2'b00};
                        data_we_d    = (cmem_q_req_type_i == WRITE);
                        data_be_d    = al_be;
                        data_wdata_d = al_wdata;
                        state_d      = REQ;
                    end else begin
                        // Answer immediately with an error; the bus is untouched.
                        rdata_d  = 32'h0;
                        status_d = 1'b1;
                        state_d  = RSP;
                    end
                end
            end
            REQ: begin
                if (data_gnt_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (data_rvalid_i) begin
                    rdata_d  = (type_q == WRITE) ? 32'h0 : al_rdata;
                    status_d = data_err_i;
                    state_d  = RSP;
                end
            end
            RSP: begin
                if (cmem_p_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            off_q        <= 2'b00;
            size_q       <= 2'b00;
            type_q       <= READ;
            id_q         <= '0;
            data_addr_q  <= 32'h0;
            data_we_q    <= 1'b0;
            data_be_q    <= 4'b0000;
            data_wdata_q <= 32'h0;
            rdata_q      <= 32'h0;
            status_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            off_q        <= off_d;
            size_q       <= size_d;
            type_q       <= type_d;
            id_q         <= id_d;
            data_addr_q  <= data_addr_d;
            data_we_q    <= data_we_d;
            data_be_q    <= data_be_d;
            data_wdata_q <= data_wdata_d;
            rdata_q      <= rdata_d;
            status_q     <= status_d;
        end
    end

    assign cmem_q_ready_o  = (state_q == IDLE);
    assign cmem_p_valid_o  = (state_q == RSP);
    assign cmem_p_rdata_o  = rdata_q;
    assign cmem_p_status_o = status_q;
    assign cmem_p_id_o     = id_q;

    assign data_req_o      = (state_q == REQ);
    assign data_addr_o     = data_addr_q;
    assign data_we_o       = data_we_q;
    assign data_be_o       = data_be_q;
    assign data_wdata_o    = data_wdata_q;

endmodule
